// File: rtl/dac_stream_pacer.sv
// dac_stream_pacer
// Buffers upstream samples in a synchronous FIFO and releases one sample per
// programmable sample period into a single-entry output register that feeds
// the DAC driver. Reports fill level, underrun ticks and late ticks.
module dac_stream_pacer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int DIV_W  = 16
) (
    input  logic                     mclk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [DIV_W-1:0]         rate_div,
    input  logic                     s_axis_valid,
    output logic                     s_axis_ready,
    input  logic [DATA_W-1:0]        s_axis_data,
    output logic                     m_axis_valid,
    input  logic                     m_axis_ready,
    output logic [DATA_W-1:0]        m_axis_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     underrun,
    output logic                     late,
    output logic [15:0]              underrun_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    // Storage and registered state
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              s_ready_q, s_ready_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  period_q, period_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              underrun_q, underrun_d;
    logic              late_q, late_d;
    logic [15:0]       ucnt_q, ucnt_d;

    // Per-cycle events
    logic accept_s;
    logic reg_free_s;
    logic fifo_empty_s;
    logic tick_s;
    logic push_s;
    logic pop_s;
    logic under_s;
    logic late_evt_s;

    // Event decode: handshakes, divider tick and what the tick does.
    always_comb begin
        accept_s     = out_valid_q && m_axis_ready;
        // A register being drained this cycle is free for a same-cycle reload.
        reg_free_s   = !out_valid_q || accept_s;
        // Empty test uses the level before any same-cycle push.
        fifo_empty_s = (level_q == '0);
        tick_s       = en && (cnt_q == period_q);
        push_s       = s_axis_valid && s_ready_q;
        pop_s        = tick_s && reg_free_s && !fifo_empty_s;
        under_s      = tick_s && reg_free_s && fifo_empty_s;
        late_evt_s   = tick_s && !reg_free_s;
    end

    // Next-state computation for divider, FIFO bookkeeping and output register.
    always_comb begin
        cnt_d       = cnt_q;
        period_d    = period_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        underrun_d  = under_s;
        late_d      = late_q | late_evt_s;
        ucnt_d      = ucnt_q;

        // Divider: held at zero while disabled, wraps at the period.
        if (!en) begin
            cnt_d = '0;
        end else if (tick_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end

        // New period only takes effect at a period boundary or while idle.
        if (!en || tick_s) begin
            period_d = rate_div;
        end else begin
            period_d = period_q;
        end

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // Output register: a pop reloads it, acceptance alone empties it.
        if (pop_s) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_q[rd_ptr_q];
        end else if (accept_s) begin
            out_valid_d = 1'b0;
            out_data_d  = out_data_q;
        end else begin
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
        end

        if (under_s && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end else begin
            ucnt_d = ucnt_q;
        end
    end

    // Ready is registered and reflects whether the next state has room.
    always_comb begin
        s_ready_d = (level_d != FULL_LVL);
    end

    // FIFO storage write; contents need no reset since pointers define validity.
    always_ff @(posedge mclk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= s_axis_data;
        end
    end

    // State register with synchronous reset; period is sampled during reset.
    always_ff @(posedge mclk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            s_ready_q   <= 1'b0;
            cnt_q       <= '0;
            period_q    <= rate_div;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            underrun_q  <= 1'b0;
            late_q      <= 1'b0;
            ucnt_q      <= 16'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            s_ready_q   <= s_ready_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            underrun_q  <= underrun_d;
            late_q      <= late_d;
            ucnt_q      <= ucnt_d;
        end
    end

    assign s_axis_ready = s_ready_q;
    assign m_axis_valid = out_valid_q;
    assign m_axis_data  = out_data_q;
    assign fifo_level   = level_q;
    assign underrun     = underrun_q;
    assign late         = late_q;
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_dac_stream_pacer.sv
// Self-checking bench for dac_stream_pacer: scoreboard of pushed samples
// compared against samples the DAC side accepts, plus per-scenario checks.
module tb_dac_stream_pacer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int DIV_W  = 16;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              mclk = 1'b0;
    logic              rst;
    logic              en;
    logic [DIV_W-1:0]  rate_div;
    logic              s_axis_valid;
    logic              s_axis_ready;
    logic [DATA_W-1:0] s_axis_data;
    logic              m_axis_valid;
    logic              m_axis_ready;
    logic [DATA_W-1:0] m_axis_data;
    logic [LVL_W-1:0]  fifo_level;
    logic              underrun;
    logic              late;
    logic [15:0]       underrun_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int vcnt     = 0;
    int under_seen = 0;
    int got_idx  = 0;

    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] got_data [$];
    int                got_cyc [$];

    dac_stream_pacer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .mclk        (mclk),
        .rst         (rst),
        .en          (en),
        .rate_div    (rate_div),
        .s_axis_valid(s_axis_valid),
        .s_axis_ready(s_axis_ready),
        .s_axis_data (s_axis_data),
        .m_axis_valid(m_axis_valid),
        .m_axis_ready(m_axis_ready),
        .m_axis_data (m_axis_data),
        .fifo_level  (fifo_level),
        .underrun    (underrun),
        .late        (late),
        .underrun_cnt(underrun_cnt)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) cyc <= cyc + 1;

    // Output monitor: records accepted samples and counts valid/underrun cycles.
    always @(negedge mclk) begin
        if (!rst) begin
            if (m_axis_valid && m_axis_ready) begin
                got_data.push_back(m_axis_data);
                got_cyc.push_back(cyc);
            end
            if (m_axis_valid) vcnt <= vcnt + 1;
            if (underrun) under_seen <= under_seen + 1;
        end
    end

    task automatic tick_clk();
        @(posedge mclk);
        #1;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d);
        bit ok;
        ok = 1'b0;
        s_axis_valid = 1'b1;
        s_axis_data  = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (s_axis_ready) begin
                ok = 1'b1;
                exp_q.push_back(d);
            end
            tick_clk();
        end
        s_axis_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL push_timeout data=%0h ready=%0b required=1", d, s_axis_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; rate_div = 16'd0;
        s_axis_valid = 1'b0; s_axis_data = 16'd0; m_axis_ready = 1'b0;
        repeat (3) tick_clk();
        checks++;
        if ({m_axis_valid, underrun, late, s_axis_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b required=0000", {m_axis_valid, underrun, late, s_axis_ready});
        end
        checks++;
        if (m_axis_data !== 16'd0 || fifo_level !== 5'd0 || underrun_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_values data=%0h level=%0d ucnt=%0d required 0/0/0", m_axis_data, fifo_level, underrun_cnt);
        end
        rst = 1'b0;
        tick_clk();
        checks++;
        if (s_axis_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%0b required=1", s_axis_ready);
        end
    endtask

    task automatic test_prefill();
        en = 1'b0; rate_div = 16'd99;
        push_word(16'hCAFE);
        push_word(16'hBEEF);
        push_word(16'hFACE);
        push_word(16'hC0DE);
        checks++;
        if (fifo_level !== 5'd4) begin
            failures++;
            $display("FAIL prefill_level got=%0d required=4", fifo_level);
        end
        repeat (20) tick_clk();
        checks++;
        if (fifo_level !== 5'd4 || m_axis_valid !== 1'b0 || underrun_cnt !== 16'd0 || under_seen != 0) begin
            failures++;
            $display("FAIL prefill_no_tick level=%0d valid=%0b ucnt=%0d required 4/0/0", fifo_level, m_axis_valid, underrun_cnt);
        end
    endtask

    task automatic test_paced();
        int c0;
        int v0;
        int n;
        m_axis_ready = 1'b1;
        v0 = vcnt;
        c0 = cyc;
        en = 1'b1;
        n = 0;
        while (got_data.size() < got_idx + 4 && n < 600) begin
            tick_clk();
            n++;
        end
        checks++;
        if (got_data.size() < got_idx + 4) begin
            failures++;
            $display("FAIL paced_timeout outputs=%0d required=4", got_data.size() - got_idx);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got_cyc[got_idx + k] != c0 + 100 * (k + 1)) begin
                    failures++;
                    $display("FAIL paced_spacing idx=%0d got=%0d required=%0d", k, got_cyc[got_idx + k] - c0, 100 * (k + 1));
                end
            end
        end
        while (got_idx < got_data.size()) begin
            checks++;
            if (exp_q.size() == 0 || got_data[got_idx] !== exp_q[0]) begin
                failures++;
                $display("FAIL paced_data got=%0h required=%0h", got_data[got_idx], (exp_q.size() == 0) ? 16'hxxxx : exp_q[0]);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            got_idx++;
        end
        tick_clk();
        checks++;
        if (vcnt - v0 != 4 || fifo_level !== 5'd0) begin
            failures++;
            $display("FAIL paced_valid_cycles got=%0d level=%0d required 4/0", vcnt - v0, fifo_level);
        end
    endtask

    task automatic test_underrun();
        int u0;
        int v0;
        int n;
        u0 = under_seen;
        v0 = vcnt;
        n = 0;
        while (under_seen < u0 + 3 && n < 400) begin
            tick_clk();
            n++;
        end
        repeat (10) tick_clk();
        checks++;
        if (under_seen - u0 != 3) begin
            failures++;
            $display("FAIL underrun_pulses got=%0d required=3", under_seen - u0);
        end
        checks++;
        if (underrun_cnt !== 16'd3) begin
            failures++;
            $display("FAIL underrun_cnt got=%0d required=3", underrun_cnt);
        end
        checks++;
        if (vcnt != v0 || late !== 1'b0) begin
            failures++;
            $display("FAIL underrun_quiet valid_cycles=%0d late=%0b required 0/0", vcnt - v0, late);
        end
    endtask

    task automatic test_back_pressure();
        int c0;
        int n;
        bit stable_ok;
        en = 1'b0; m_axis_ready = 1'b0;
        tick_clk();
        rate_div = 16'd3;
        push_word(16'h0001);
        push_word(16'h0002);
        c0 = cyc;
        en = 1'b1;
        stable_ok = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick_clk();
            if (i >= 4 && !(m_axis_valid === 1'b1 && m_axis_data === 16'h0001)) stable_ok = 1'b0;
        end
        checks++;
        if (!stable_ok) begin
            failures++;
            $display("FAIL bp_hold valid=%0b data=%0h required 1/0001", m_axis_valid, m_axis_data);
        end
        checks++;
        if (late !== 1'b1 || fifo_level !== 5'd1) begin
            failures++;
            $display("FAIL bp_late late=%0b level=%0d required 1/1", late, fifo_level);
        end
        m_axis_ready = 1'b1;
        n = 0;
        while (got_data.size() < got_idx + 2 && n < 50) begin
            tick_clk();
            n++;
        end
        checks++;
        if (got_data.size() < got_idx + 2) begin
            failures++;
            $display("FAIL bp_timeout outputs=%0d required=2", got_data.size() - got_idx);
        end else if (got_cyc[got_idx + 1] != c0 + 12) begin
            failures++;
            $display("FAIL bp_second_tick got=%0d required=12", got_cyc[got_idx + 1] - c0);
        end
        while (got_idx < got_data.size()) begin
            checks++;
            if (exp_q.size() == 0 || got_data[got_idx] !== exp_q[0]) begin
                failures++;
                $display("FAIL bp_data got=%0h required=%0h", got_data[got_idx], (exp_q.size() == 0) ? 16'hxxxx : exp_q[0]);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            got_idx++;
        end
        en = 1'b0;
        tick_clk();
    endtask

    task automatic test_full_fifo();
        int n;
        en = 1'b0; m_axis_ready = 1'b1; rate_div = 16'd0;
        for (int i = 0; i < DEPTH; i++) push_word(16'(i));
        checks++;
        if (fifo_level !== 5'd16 || s_axis_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_level level=%0d ready=%0b required 16/0", fifo_level, s_axis_ready);
        end
        s_axis_valid = 1'b1;
        s_axis_data  = 16'd16;
        repeat (5) tick_clk();
        checks++;
        if (fifo_level !== 5'd16 || s_axis_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_hold level=%0d ready=%0b required 16/0", fifo_level, s_axis_ready);
        end
        en = 1'b1;
        n = 0;
        while (!s_axis_ready && n < 20) begin
            tick_clk();
            n++;
        end
        checks++;
        if (n != 1 || fifo_level !== 5'd15) begin
            failures++;
            $display("FAIL full_ready_rise cycles=%0d level=%0d required 1/15", n, fifo_level);
        end
        push_word(16'd16);
        push_word(16'd17);
        n = 0;
        while (got_data.size() < got_idx + 18 && n < 100) begin
            tick_clk();
            n++;
        end
        checks++;
        if (got_data.size() != got_idx + 18) begin
            failures++;
            $display("FAIL full_outputs got=%0d required=18", got_data.size() - got_idx);
        end
        while (got_idx < got_data.size()) begin
            checks++;
            if (exp_q.size() == 0 || got_data[got_idx] !== exp_q[0]) begin
                failures++;
                $display("FAIL full_data got=%0h required=%0h", got_data[got_idx], (exp_q.size() == 0) ? 16'hxxxx : exp_q[0]);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            got_idx++;
        end
        en = 1'b0;
        tick_clk();
    endtask

    task automatic test_reset_mid();
        int g0;
        int v0;
        en = 1'b0; m_axis_ready = 1'b0; rate_div = 16'd0;
        tick_clk();
        for (int i = 0; i < 6; i++) push_word(16'hA0 + 16'(i));
        en = 1'b1;
        tick_clk();
        en = 1'b0;
        checks++;
        if (m_axis_valid !== 1'b1 || fifo_level !== 5'd5) begin
            failures++;
            $display("FAIL mid_precond valid=%0b level=%0d required 1/5", m_axis_valid, fifo_level);
        end
        rst = 1'b1;
        tick_clk();
        checks++;
        if ({m_axis_valid, underrun, late, s_axis_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset_flags got=%b required=0000", {m_axis_valid, underrun, late, s_axis_ready});
        end
        checks++;
        if (m_axis_data !== 16'd0 || fifo_level !== 5'd0 || underrun_cnt !== 16'd0) begin
            failures++;
            $display("FAIL mid_reset_values data=%0h level=%0d ucnt=%0d required 0/0/0", m_axis_data, fifo_level, underrun_cnt);
        end
        exp_q.delete();
        rst = 1'b0;
        tick_clk();
        checks++;
        if (s_axis_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_release_ready got=%0b required=1", s_axis_ready);
        end
        g0 = got_data.size();
        v0 = vcnt;
        m_axis_ready = 1'b1;
        en = 1'b1;
        repeat (20) tick_clk();
        checks++;
        if (got_data.size() != g0 || vcnt != v0 || fifo_level !== 5'd0) begin
            failures++;
            $display("FAIL mid_stale outputs=%0d valid_cycles=%0d level=%0d required 0/0/0", got_data.size() - g0, vcnt - v0, fifo_level);
        end
        got_idx = got_data.size();
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_paced();
        test_underrun();
        test_back_pressure();
        test_full_fifo();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dac_stream_pacer.md
Name: dac_stream_pacer

Overview:
Sample-rate pacing stage that sits directly upstream of the AD5541A SPI DAC driver. It buffers 16-bit samples arriving on an AXI-Stream slave in a synchronous FIFO and releases exactly one sample per programmable sample period on an AXI-Stream master wired to the driver's s_axis_* inputs. It reports FIFO fill level, underruns (a tick with no sample available) and late ticks (a tick while the previous sample is still unaccepted by the driver).

Parameters:
DATA_W, 16, sample width; matches the DAC word.
DEPTH, 16, FIFO depth in entries; power of 2, minimum 2.
DIV_W, 16, width of the rate divider.

Ports:
mclk  in  1  system clock
rst  in  1  synchronous, active-high reset; clock mclk
en  in  1  pacing enable; FIFO still accepts writes when low
rate_div  in  DIV_W  sample period minus 1, in mclk cycles
s_axis_valid  in  1  upstream sample valid
s_axis_ready  out  1  FIFO can accept a sample
s_axis_data  in  DATA_W  upstream sample
m_axis_valid  out  1  sample valid to the DAC driver
m_axis_ready  in  1  DAC driver ready
m_axis_data  out  DATA_W  sample to the DAC driver
fifo_level  out  $clog2(DEPTH)+1  FIFO entries; the output register is not counted
underrun  out  1  one-cycle pulse per underrun tick
late  out  1  sticky; set on a late tick, cleared only by rst
underrun_cnt  out  16  saturating underrun count

Behaviour:
- Reset (rst=1 at a mclk edge): FIFO emptied, fifo_level=0, m_axis_valid=0, m_axis_data=0, underrun=0, late=0, underrun_cnt=0, s_axis_ready=0, divider count=0. s_axis_ready goes to 1 on the first cycle after rst deasserts. Reset mid-transfer discards all buffered and held data.
- Push: when s_axis_valid && s_axis_ready, write s_axis_data; fifo_level increments next cycle. s_axis_ready is registered and equals !full of the next state.
- Divider: count runs 0..period_q and wraps. A tick occurs on the cycle where count==period_q and en=1.
  - period_q is loaded from rate_div at reset exit, at every tick, and on every cycle while en=0, so a mid-period change applies from the next period.
  - rate_div=0 gives a tick every cycle. en=0 holds count at 0, with no ticks.
- Output register (single entry): on a tick, the FIFO empty test uses the level before any same-cycle push.
  - If the register is empty and the FIFO is non-empty: pop into m_axis_data, and m_axis_valid=1 on the next cycle. Tick-to-valid latency is 1 cycle.
  - If the register is empty and the FIFO is empty: underrun=1 for the next cycle, and underrun_cnt+1 saturating at 16'hFFFF. No output occurs and no sample is repeated.
  - If the register is full (m_axis_valid=1 and not accepted this cycle): late<=1 and the tick is dropped. No pop occurs.
  - If the register is full but the handshake completes in the same cycle: the register counts as empty, so a normal pop/underrun occurs.
- Master handshake: m_axis_valid and m_axis_data stay stable until m_axis_valid && m_axis_ready. m_axis_valid clears the cycle after acceptance unless a same-cycle pop reloads it. Deasserting en never drops a held sample.
- FIFO order is strict first-in first-out. Simultaneous push and pop leave fifo_level unchanged. Pointers wrap modulo DEPTH.
- At full, s_axis_ready=0. A pop at full raises s_axis_ready the next cycle.
- Outputs m_axis_valid, m_axis_data, underrun, late, underrun_cnt and fifo_level are all registered.

Test Plan:
- Prefill with en=0: push 16'hCAFE, BEEF, FACE, C0DE. Then fifo_level=4, m_axis_valid=0, with no ticks.
- Paced output: rate_div=99, en=1, m_axis_ready=1. The four samples appear in order, each m_axis_valid high for exactly one cycle, spaced 100 mclk cycles apart, with the first valid 1 cycle after the first tick. After that, fifo_level=0.
- Underrun: continue the previous run with no pushes for 3 ticks. Result: 3 underrun pulses, underrun_cnt=3, m_axis_valid stays 0 and late=0.
- Back-pressure: rate_div=3 and m_axis_ready held low for 10 cycles with samples 16'h0001 and 16'h0002 queued. m_axis_data holds 16'h0001 stable, late=1, and fifo_level stays 1. After ready rises, 16'h0002 is output at the next tick.
- Full FIFO: with en=0, push DEPTH+2 samples 0..17. s_axis_ready falls after 16 pushes and fifo_level=16. Samples 16 and 17 are held upstream and accepted only after pops.
- Reset mid-operation: assert rst while m_axis_valid=1 and fifo_level=5. The next cycle shows all outputs at reset values. One cycle after release, s_axis_ready=1, and no stale sample ever appears.
